// File: rtl/params_pkg.sv
// Shared parameters and types for the AXI burst splitter.
// Holds the bus-width defaults, the AXI 4 KB boundary constant,
// the AXI burst-type encoding and the splitter FSM state type.
package params_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int BUS_AIW         = 8;

  // AXI bursts must never cross this many bytes.
  localparam int AXI_4K_BOUNDARY = 4096;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } splitter_state_t;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Combinational burst-size calculator for the AXI burst splitter.
// The result is the smallest of three limits: the beats still owed,
// the configured maximum burst length, and the beats that fit before
// the next 4 KB boundary.
module axi_burst_len_calc #(
  parameter int ADDR_WIDTH    = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = params_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [8:0]            burst
);
  import params_pkg::*;

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);

  logic [12:0] bytes_to_4k;
  logic [12:0] beats_to_4k;
  logic        unused_addr_hi;

  // Only the offset within the current 4 KB page matters here.
  assign unused_addr_hi = ^addr[ADDR_WIDTH-1:12];

  // Clamp to the max burst first, then to remaining beats, then to the page end.
  always_comb begin
    bytes_to_4k = 13'(AXI_4K_BOUNDARY) - {1'b0, addr[11:0]};
    beats_to_4k = bytes_to_4k >> SIZE_LOG2;
    burst       = 9'(MAX_BURST_LEN);
    if (32'(remaining) < 32'(MAX_BURST_LEN)) begin
      burst = 9'(remaining);
    end
    if (32'(beats_to_4k) < 32'(burst)) begin
      burst = 9'(beats_to_4k);
    end
  end

endmodule

// File: rtl/axi_burst_splitter.sv
// AXI burst splitter: turns one long command (address + length in beats)
// into a series of INCR bursts on an AXI address channel, each no longer
// than MAX_BURST_LEN and never crossing a 4 KB boundary. cmd_done pulses
// for one cycle after the last burst is accepted (or after a zero-length
// command is accepted).
// Optional feature: define AXI_BURST_SPLITTER_STATS_EN to add saturating
// burst_count / cmd_count statistics outputs.
module axi_burst_splitter #(
  parameter int ADDR_WIDTH    = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = params_pkg::DATA_WIDTH,
  parameter int ID_WIDTH      = params_pkg::BUS_AIW,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  output logic                  ax_valid,
  input  logic                  ax_ready,
  output logic [ADDR_WIDTH-1:0] ax_addr,
  output logic [7:0]            ax_len,
  output logic [2:0]            ax_size,
  output logic [1:0]            ax_burst,
  output logic [ID_WIDTH-1:0]   ax_id,
  output logic                  cmd_done
`ifdef AXI_BURST_SPLITTER_STATS_EN
  ,
  output logic [31:0]           burst_count,
  output logic [31:0]           cmd_count
`endif
);
  import params_pkg::*;

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

  splitter_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  done_q;
  logic [8:0]            burst;
  logic                  cmd_fire;
  logic                  cmd_zero;
  logic                  ax_fire;
  logic                  last_burst;

  axi_burst_len_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len_calc (
    .addr      (addr_q),
    .remaining (rem_q),
    .burst     (burst)
  );

  assign cmd_fire   = cmd_ready && cmd_valid && (cmd_len != '0);
  assign cmd_zero   = cmd_ready && cmd_valid && (cmd_len == '0);
  assign ax_fire    = ax_valid && ax_ready;
  assign last_burst = (rem_q == LEN_WIDTH'(burst));

  // FSM state register; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start issuing on a non-empty command, stop after the final burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid && (cmd_len != '0)) state_d = ISSUE;
      ISSUE:   if (ax_ready && last_burst) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept commands only when idle, present a burst only while issuing.
  always_comb begin
    cmd_ready = 1'b0;
    ax_valid  = 1'b0;
    ax_len    = 8'd0;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      ISSUE: begin
        ax_valid = 1'b1;
        ax_len   = 8'(burst - 9'd1);
      end
      default: ;
    endcase
  end

  // Command payload: latch aligned address on accept, advance after each burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      id_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= cmd_zero || (ax_fire && last_burst);
      if (cmd_fire) begin
        addr_q <= cmd_addr & ~ALIGN_MASK;
        rem_q  <= cmd_len;
        id_q   <= cmd_id;
      end else if (ax_fire) begin
        addr_q <= addr_q + (ADDR_WIDTH'(burst) << SIZE_LOG2);
        rem_q  <= rem_q - LEN_WIDTH'(burst);
      end
    end
  end

  assign ax_addr  = addr_q;
  assign ax_size  = 3'(SIZE_LOG2);
  assign ax_burst = 2'(INCR);
  assign ax_id    = id_q;
  assign cmd_done = done_q;

`ifdef AXI_BURST_SPLITTER_STATS_EN
  // Saturating counters of accepted bursts and completed commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_count <= '0;
      cmd_count   <= '0;
    end else begin
      if (ax_fire && (burst_count != '1)) begin
        burst_count <= burst_count + 32'd1;
      end
      if (done_q && (cmd_count != '1)) begin
        cmd_count <= cmd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/axi_burst_splitter.md
AXI_BURST_SPLITTER -- requirements
Module: axi_burst_splitter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the AXI address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the bus data width; it is a power-of-two multiple of 8, and BYTES = DATA_WIDTH/8.
REQ-003 The block SHALL have parameter ID_WIDTH, default 8, the AXI ID width.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 16, the width of the command length field in beats.
REQ-005 The block SHALL have parameter MAX_BURST_LEN, default 256, the maximum beats per burst; legal range is 1..256.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-008 The block SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): the command handshake.
REQ-009 The block SHALL have ports cmd_addr (input, ADDR_WIDTH), cmd_len (input, LEN_WIDTH, in beats) and cmd_id (input, ID_WIDTH).
REQ-010 The block SHALL have ports ax_valid (output, 1) and ax_ready (input, 1): the AXI address-channel handshake.
REQ-011 The block SHALL have outputs ax_addr (ADDR_WIDTH), ax_len (8), ax_size (3), ax_burst (2) and ax_id (ID_WIDTH).
REQ-012 The block SHALL have output cmd_done, 1 bit: a single-cycle pulse marking command completion.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and ISSUE.
REQ-014 In IDLE the block SHALL drive cmd_ready=1 and ax_valid=0.
REQ-015 In ISSUE the block SHALL drive cmd_ready=0 and ax_valid=1.
REQ-016 On an IDLE handshake with cmd_len!=0, the block SHALL latch addr, remaining and id, then enter ISSUE, so ax_valid rises the next cycle.
REQ-017 The block SHALL force the low log2(BYTES) bits of the latched address to zero.
REQ-018 A command with cmd_len==0 SHALL leave the block in IDLE, pulse cmd_done in the following cycle, and issue no burst.
REQ-019 The burst size in beats SHALL be min(remaining, MAX_BURST_LEN, (4096 - addr[11:0])/BYTES), so no burst crosses a 4 KB boundary.
REQ-020 The block SHALL drive ax_len = burst-1, ax_size = log2(BYTES), ax_burst = 2'b01 (INCR) and ax_id = latched id.
REQ-021 All ax_* payload SHALL stay stable while ax_valid=1 and ax_ready=0.
REQ-022 On an ax handshake, addr SHALL advance by burst*BYTES and remaining SHALL decrease by burst.
REQ-023 When remaining equals burst at the handshake, the block SHALL return to IDLE and pulse cmd_done in the next cycle.
REQ-024 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH without error.
REQ-025 cmd_valid asserted during ISSUE SHALL be ignored, since cmd_ready=0.

Reset
REQ-026 While rst=1 the block SHALL immediately drive state=IDLE, ax_valid=0, cmd_done=0, and hold all payload registers at 0.
REQ-027 Asserting rst mid-command SHALL abandon the command with no cmd_done.
REQ-028 In the first clk edge after rst deasserts, cmd_ready SHALL be 1.

Configuration
REQ-029 With macro AXI_BURST_SPLITTER_STATS_EN defined, the block SHALL add outputs burst_count (32) and cmd_count (32).
REQ-030 burst_count SHALL increment on each ax handshake, and cmd_count on each cmd_done; both saturate at all-ones and reset to 0.
REQ-031 Without AXI_BURST_SPLITTER_STATS_EN, those ports and counters SHALL NOT exist and function SHALL be otherwise identical.

Structure
REQ-032 params_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH and BUS_AIW (used as the ID_WIDTH default).
REQ-033 params_pkg SHALL also hold a new constant AXI_4K_BOUNDARY=4096 and an enum axi_burst_t (FIXED, INCR, WRAP).
REQ-034 The burst-size computation SHALL be a combinational sub-module axi_burst_len_calc, with inputs addr, remaining and MAX_BURST_LEN and output burst.

Verification
REQ-035 The bench SHALL check: addr 0x1000, len 16 -> one burst with ax_addr 0x1000, ax_len 15, ax_size 2, then cmd_done.
REQ-036 The bench SHALL check: addr 0x0FF0, len 8 -> bursts (0x0FF0, ax_len 3) then (0x1000, ax_len 3).
REQ-037 The bench SHALL check: addr 0x0, len 600 -> bursts ax_len 255/255/87 at ax_addr 0x000/0x400/0x800.
REQ-038 The bench SHALL check: ax_ready held low for 5 cycles -> ax_valid held high and payload unchanged.
REQ-039 The bench SHALL check: len 0 -> cmd_done one cycle after accept, with ax_valid never high.
REQ-040 The bench SHALL check: rst pulsed during ISSUE -> ax_valid 0 in the same cycle, no cmd_done, and cmd_ready 1 after release.
